// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns the debounced switch level into one-cycle user events (press,
// release, single click, double click, long press) plus a held level.
// All event outputs are registered: a pulse appears in the cycle after the
// clock edge that sampled the triggering switch edge or terminal count.
// o_State mirrors the FSM state register for debug and checker binding.
module button_event_decoder #(
  parameter int c_LONG_PRESS_LIMIT = 25000000,
  parameter int c_DOUBLE_GAP_LIMIT = 6250000,
  parameter int c_CNT_WIDTH        = 26
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch,
  output logic       o_Press,
  output logic       o_Release,
  output logic       o_Single,
  output logic       o_Double,
  output logic       o_Long,
  output logic       o_Held,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED1  = 3'd1,
    WAIT_GAP  = 3'd2,
    PRESSED2  = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so the
  // transition fires on the Nth edge spent in the state.
  localparam logic [c_CNT_WIDTH-1:0] LONG_TC = c_CNT_WIDTH'(c_LONG_PRESS_LIMIT - 1);
  localparam logic [c_CNT_WIDTH-1:0] GAP_TC  = c_CNT_WIDTH'(c_DOUBLE_GAP_LIMIT - 1);

  state_t                 state_q, state_d;
  logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;
  // Previous switch level; resets high so a switch already pressed at
  // reset release is not mistaken for a new press.
  logic                   prev_q;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   single_q, single_d;
  logic                   double_q, double_d;
  logic                   long_q, long_d;
  logic                   held_q, held_d;
  logic                   rise, fall, counting;

  assign rise     = i_Switch & ~prev_q;
  assign fall     = ~i_Switch & prev_q;
  assign counting = (state_q == PRESSED1) || (state_q == WAIT_GAP) ||
                    (state_q == PRESSED2);

  // Next state and next-cycle event pulses.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    single_d  = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED1;
          press_d = 1'b1;
        end
      end
      PRESSED1: begin
        if (fall) begin
          state_d   = WAIT_GAP;
          release_d = 1'b1;
        end else if (i_Switch && (cnt_q == LONG_TC)) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      WAIT_GAP: begin
        // A second press on the terminal-count cycle still counts as a double.
        if (rise) begin
          state_d = PRESSED2;
          press_d = 1'b1;
        end else if (cnt_q == GAP_TC) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end
      end
      PRESSED2: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (i_Switch && (cnt_q == LONG_TC)) begin
          // Long press wins: the pending double click is dropped.
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d == LONG_HELD);
  end

  // Counter: cleared on every state entry, saturating count while timing.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (counting && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, counter, edge history and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= i_Switch;
      press_q   <= press_d;
      release_q <= release_d;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Single  = single_q;
  assign o_Double  = double_q;
  assign o_Long    = long_q;
  assign o_Held    = held_q;
  assign o_State   = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder with short limits (long=20, gap=10).
// Each gesture is described as switch-level segments plus expected event
// windows; it is expanded into per-cycle {switch, expected outputs} records
// and applied one cycle at a time through an expected-value queue.
module tb_button_event_decoder;

  localparam int L_LIMIT = 20;
  localparam int G_LIMIT = 10;
  localparam int CNT_W   = 5;

  // Output bit positions: {held, long, double, single, release, press}
  localparam logic [5:0] PRS = 6'b000001;
  localparam logic [5:0] REL = 6'b000010;
  localparam logic [5:0] SGL = 6'b000100;
  localparam logic [5:0] DBL = 6'b001000;
  localparam logic [5:0] LNG = 6'b010000;
  localparam logic [5:0] HLD = 6'b100000;

  typedef struct {logic sw; int len;} seg_t;
  typedef struct {int first; int last; logic [5:0] mask;} evt_t;
  typedef struct {logic sw; logic [5:0] exp;} vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw = 1'b0;
  logic       o_press, o_release, o_single, o_double, o_long, o_held;
  logic [2:0] o_state;

  int         errors = 0;
  int         checks = 0;
  logic [5:0] exp_q[$];
  seg_t       segs[$];
  evt_t       evts[$];

  // Clock / reset
  always #5 clk = ~clk;

  button_event_decoder #(
    .c_LONG_PRESS_LIMIT(L_LIMIT),
    .c_DOUBLE_GAP_LIMIT(G_LIMIT),
    .c_CNT_WIDTH       (CNT_W)
  ) dut (
    .i_Clk    (clk),
    .i_Rst_L  (rst_n),
    .i_Switch (sw),
    .o_Press  (o_press),
    .o_Release(o_release),
    .o_Single (o_single),
    .o_Double (o_double),
    .o_Long   (o_long),
    .o_Held   (o_held),
    .o_State  (o_state)
  );

  function automatic logic [5:0] outs();
    return {o_held, o_long, o_double, o_single, o_release, o_press};
  endfunction

  task automatic check_outs(input string name, input int cyc, input logic [5:0] req);
    logic [5:0] act;
    act = outs();
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: outputs(hld,lng,dbl,sgl,rel,prs)=%b required %b",
               name, cyc, act, req);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (o_state !== 3'd0) begin
      errors++;
      $display("FAIL %s: state=%0d required 0 (IDLE)", name, o_state);
    end
  endtask

  // Driver: present one switch sample, record its expectation, then compare
  // the registered outputs produced by that clock edge.
  task automatic drive(input string name, input int cyc, input logic s, input logic [5:0] e);
    logic [5:0] req;
    sw = s;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req = exp_q.pop_front();
    check_outs(name, cyc, req);
  endtask

  task automatic add_seg(input logic s, input int len);
    seg_t g;
    g.sw = s;
    g.len = len;
    segs.push_back(g);
  endtask

  task automatic add_evt(input int first, input int last, input logic [5:0] mask);
    evt_t v;
    v.first = first;
    v.last = last;
    v.mask = mask;
    evts.push_back(v);
  endtask

  // Expand segments/events into a vector table (with `lead` idle-low cycles
  // in front so the first high is a real rise), apply it, then confirm IDLE.
  task automatic run(input string name, input int lead);
    vec_t vecs[$];
    vec_t v;
    for (int i = 0; i < lead; i++) begin
      v.sw = 1'b0;
      v.exp = '0;
      vecs.push_back(v);
    end
    foreach (segs[k]) begin
      for (int i = 0; i < segs[k].len; i++) begin
        v.sw = segs[k].sw;
        v.exp = '0;
        vecs.push_back(v);
      end
    end
    foreach (evts[k]) begin
      for (int c = evts[k].first; c <= evts[k].last; c++) begin
        vecs[c + lead].exp = vecs[c + lead].exp | evts[k].mask;
      end
    end
    for (int i = 0; i < vecs.size(); i++) begin
      drive(name, i - lead, vecs[i].sw, vecs[i].exp);
    end
    check_idle({name, "_end_idle"});
    segs.delete();
    evts.delete();
  endtask

  task automatic single_click(input string name, input int lead);
    add_seg(1'b1, 5);
    add_seg(1'b0, 15);
    add_evt(0, 0, PRS);
    add_evt(5, 5, REL);
    add_evt(15, 15, SGL);
    run(name, lead);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    sw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_outputs", 0, 6'b0);
    check_idle("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Single click
    single_click("single_click", 2);

    // 2. Double click
    add_seg(1'b1, 5); add_seg(1'b0, 4); add_seg(1'b1, 5); add_seg(1'b0, 15);
    add_evt(0, 0, PRS); add_evt(5, 5, REL); add_evt(9, 9, PRS);
    add_evt(14, 14, REL | DBL);
    run("double_click", 2);

    // 3. Long press
    add_seg(1'b1, 30); add_seg(1'b0, 5);
    add_evt(0, 0, PRS); add_evt(20, 20, LNG); add_evt(20, 29, HLD);
    add_evt(30, 30, REL);
    run("long_press", 2);

    // 4a. Second rise on the gap terminal-count cycle: still a double
    add_seg(1'b1, 5); add_seg(1'b0, 10); add_seg(1'b1, 5); add_seg(1'b0, 15);
    add_evt(0, 0, PRS); add_evt(5, 5, REL); add_evt(15, 15, PRS);
    add_evt(20, 20, REL | DBL);
    run("gap_edge_double", 2);

    // 4b. Second rise one cycle too late: single, then a fresh click
    add_seg(1'b1, 5); add_seg(1'b0, 11); add_seg(1'b1, 5); add_seg(1'b0, 15);
    add_evt(0, 0, PRS); add_evt(5, 5, REL); add_evt(15, 15, SGL);
    add_evt(16, 16, PRS); add_evt(21, 21, REL); add_evt(31, 31, SGL);
    run("gap_late_single", 2);

    // 5. Reset mid-pulse with the switch held high in PRESSED1
    drive("rst_pre", 0, 1'b0, 6'b0);
    drive("rst_pre", 1, 1'b0, 6'b0);
    drive("rst_press", 2, 1'b1, PRS);
    rst_n = 1'b0;
    #1;
    check_outs("rst_async_clear", 0, 6'b0);
    check_idle("rst_async_state");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outs("rst_hold", i, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Switch held through reset: no events on hold or release
    add_seg(1'b1, 5); add_seg(1'b0, 15);
    run("post_reset_held", 0);
    single_click("post_reset_click", 0);

    // 6. Long press on the second click
    add_seg(1'b1, 5); add_seg(1'b0, 3); add_seg(1'b1, 25); add_seg(1'b0, 15);
    add_evt(0, 0, PRS); add_evt(5, 5, REL); add_evt(8, 8, PRS);
    add_evt(28, 28, LNG); add_evt(28, 32, HLD); add_evt(33, 33, REL);
    run("long_second_click", 2);

    // Randomised single clicks with varying press lengths
    for (int r = 0; r < 4; r++) begin
      int hi;
      hi = $urandom_range(1, 15);
      add_seg(1'b1, hi); add_seg(1'b0, 14);
      add_evt(0, 0, PRS); add_evt(hi, hi, REL); add_evt(hi + 10, hi + 10, SGL);
      run("rand_single", 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
